// File: rtl/ras_pkg.sv
// Shared defaults and types for the return-address stack.
package ras_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DEPTH_DEF  = 8;
    localparam int PTR_W_DEF  = $clog2(DEPTH_DEF);

    typedef logic [ADDR_W_DEF-1:0] ras_addr_t;

endpackage

// File: rtl/ras_storage.sv
// DEPTH x ADDR_W link-address array: one synchronous write port, one async read port.
module ras_storage
    import ras_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [ADDR_W-1:0] rdata
);

    // Entries are never reset; validity is tracked by the owner's count.
    logic [ADDR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/return_addr_stack.sv
// Circular LIFO of jal link addresses predicting the next jr $ra target.
// Optional misprediction checker enabled by defining RAS_CHECK_EN.
module return_addr_stack
    import ras_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              pop,
    input  logic [ADDR_W-1:0] actual_addr,
    output logic              pred_valid,
    output logic [ADDR_W-1:0] pred_addr,
    output logic              full,
    output logic              empty,
    output logic [PTR_W:0]    count,
    output logic              overflow,
    output logic              underflow
`ifdef RAS_CHECK_EN
    ,
    output logic              mispredict,
    output logic [15:0]       mispredict_cnt
`endif
);

    localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

    logic [PTR_W-1:0] tos_q, tos_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_ptr;
    logic             is_full;
    logic             is_empty;

    assign is_full  = (count_q == DEPTH_C);
    assign is_empty = (count_q == '0);

    always_comb begin
        tos_d       = tos_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        wr_en       = 1'b0;
        wr_ptr      = tos_q;
        if (flush) begin
            count_d = '0;
        end else if (push && (!pop || is_empty)) begin
            // A push+pop on an empty stack has nothing to replace, so it acts as a plain push.
            tos_d  = tos_q + 1'b1;
            wr_en  = 1'b1;
            wr_ptr = tos_q + 1'b1;
            if (is_full) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (push && pop) begin
            wr_en  = 1'b1;
            wr_ptr = tos_q;
        end else if (pop) begin
            if (is_empty) begin
                underflow_d = 1'b1;
            end else begin
                tos_d   = tos_q - 1'b1;
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tos_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            tos_q       <= tos_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    ras_storage #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_storage (
        .clk   (clk),
        .we    (wr_en && rst_n),
        .waddr (wr_ptr),
        .wdata (push_addr),
        .raddr (tos_q),
        .rdata (pred_addr)
    );

    assign pred_valid = !is_empty;
    assign full       = is_full;
    assign empty      = is_empty;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

`ifdef RAS_CHECK_EN
    logic        mispredict_q, mispredict_d;
    logic [15:0] mispredict_cnt_q, mispredict_cnt_d;

    always_comb begin
        mispredict_d     = 1'b0;
        mispredict_cnt_d = mispredict_cnt_q;
        if (pop && !flush) begin
            mispredict_d = is_empty || (pred_addr != actual_addr);
        end
        if (mispredict_d && (mispredict_cnt_q != 16'hFFFF)) begin
            mispredict_cnt_d = mispredict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mispredict_q     <= 1'b0;
            mispredict_cnt_q <= '0;
        end else begin
            mispredict_q     <= mispredict_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign mispredict     = mispredict_q;
    assign mispredict_cnt = mispredict_cnt_q;
`else
    logic unused_actual_addr;
    assign unused_actual_addr = ^actual_addr;
`endif

endmodule
